mips_dmem_ctrl: RTL

Data-memory controller directly downstream of `mips_core`; it serves the core's `lw`/`sw` traffic. Each accepted word request passes through a small FSM with a parameterised wait-state count, then completes with a single-cycle response strobe. Storage is a word-addressed synchronous RAM held inside the block. Loads deliver read data on the response; stores commit on the response cycle.

---
 rtl/mips_pkg.sv | 18 +
 rtl/mips_dmem_array.sv | 24 ++
 rtl/mips_dmem_ctrl.sv | 108 ++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS data-memory slice: FSM states, word width
// and the word-index width helper.
package mips_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    DMEM_IDLE = 2'd0,
    DMEM_BUSY = 2'd1,
    DMEM_RESP = 2'd2
  } dmemState_t;

  // Number of word-index bits for a RAM of the given depth.
  function automatic int idxWidth(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/mips_dmem_array.sv
// Word-addressed synchronous single-port RAM with a registered read port.
// Contents are never reset.
module mips_dmem_array
  import mips_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [idxWidth(DEPTH)-1:0] idx,
  input  logic [WORD_W-1:0]          wdata,
  output logic [WORD_W-1:0]          rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wdata;
    end
    rdata <= mem[idx];
  end

endmodule

// File: rtl/mips_dmem_ctrl.sv
// Data-memory controller for mips_core lw/sw traffic: IDLE/BUSY/RESP FSM with
// WAIT_CYCLES stall cycles. Define MIPS_DMEM_ALIGN_CHECK_EN to fault misaligned requests.
module mips_dmem_ctrl
  import mips_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [WORD_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int AW = idxWidth(DEPTH);

  dmemState_t        state, stateNext;
  logic [3:0]        waitCnt, waitCntNext;
  logic              accept, reqErr, ramWe;
  logic              latchWe, latchErr;
  logic [AW-1:0]     latchIdx, reqIdx, ramIdx;
  logic [WORD_W-1:0] latchWdata, ramRdata;

  assign accept = req_valid & (state == DMEM_IDLE);
  assign reqIdx = req_addr[AW+1:2];

`ifdef MIPS_DMEM_ALIGN_CHECK_EN
  assign reqErr = (|req_addr[WORD_W-1:AW+2]) | (|req_addr[1:0]);
`else
  logic unusedLowBits;
  assign reqErr        = |req_addr[WORD_W-1:AW+2];
  assign unusedLowBits = ^req_addr[1:0];
`endif

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state   <= DMEM_IDLE;
      waitCnt <= 4'd0;
    end else begin
      state   <= stateNext;
      waitCnt <= waitCntNext;
    end
  end

  // Fault status is resolved at acceptance so the response needs only latched state.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      latchWe    <= 1'b0;
      latchErr   <= 1'b0;
      latchIdx   <= '0;
      latchWdata <= '0;
    end else if (accept) begin
      latchWe    <= req_we;
      latchErr   <= reqErr;
      latchIdx   <= reqIdx;
      latchWdata <= req_wdata;
    end
  end

  always_comb begin
    stateNext   = state;
    waitCntNext = waitCnt;
    unique case (state)
      DMEM_IDLE: begin
        if (accept) begin
          if (WAIT_CYCLES == 0) begin
            stateNext = DMEM_RESP;
          end else begin
            stateNext   = DMEM_BUSY;
            waitCntNext = 4'(WAIT_CYCLES);
          end
        end
      end
      DMEM_BUSY: begin
        waitCntNext = waitCnt - 4'd1;
        if (waitCnt == 4'd1) begin
          stateNext = DMEM_RESP;
        end
      end
      DMEM_RESP: stateNext = DMEM_IDLE;
      default:   stateNext = DMEM_IDLE;
    endcase
  end

  // In IDLE the RAM tracks the live request so a zero-wait load has data in RESP.
  assign ramIdx = (state == DMEM_IDLE) ? reqIdx : latchIdx;
  assign ramWe  = (state == DMEM_RESP) & latchWe & ~latchErr;

  mips_dmem_array #(.DEPTH(DEPTH)) u_array (
    .clk   (clk),
    .we    (ramWe),
    .idx   (ramIdx),
    .wdata (latchWdata),
    .rdata (ramRdata)
  );

  assign req_ready = (state == DMEM_IDLE);
  assign rsp_valid = (state == DMEM_RESP);
  assign rsp_err   = rsp_valid & latchErr;
  assign rsp_rdata = (rsp_valid & ~latchWe & ~latchErr) ? ramRdata : '0;

endmodule
